// File: rtl/sp_ram_pkg.sv
// Shared widths and word types for the single-port scratch RAM.
// Imported by the interface, the storage array and the top.
package sp_ram_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/sp_ram_if.sv
// Bus bundle for the single-port RAM.
// The dut modport is the RAM side; tb mirrors it.
interface sp_ram_if
    import sp_ram_pkg::*;
(
    input logic clk,
    input logic rst
);

    logic  en;
    addr_t addr;
    data_t data_in;
    data_t data_out;

    modport dut (
        input  clk,
        input  rst,
        input  en,
        input  addr,
        input  data_in,
        output data_out
    );

    modport tb (
        input  clk,
        input  rst,
        output en,
        output addr,
        output data_in,
        input  data_out
    );

endinterface

// File: rtl/sp_ram_mem.sv
// Storage array: one clocked write port, one clocked read port.
// No reset, so tools can map it onto block RAM.
module sp_ram_mem
    import sp_ram_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  logic  re,
    input  addr_t addr,
    input  data_t wdata,
    output data_t rdata
);

    data_t mem [DEPTH];

    // Synchronous write of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Synchronous read; the output holds between read cycles.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sp_ram_inf.sv
// Single-port RAM top: en=1 writes, en=0 reads with one cycle latency.
// data_out is zero from reset until the first read after release.
module sp_ram_inf
    import sp_ram_pkg::*;
(
    sp_ram_if.dut bus
);

    logic  we;
    logic  re;
    logic  rd_ok;
    data_t rd_data;

    // Both ports are blocked while reset is held low.
    assign we = bus.rst & bus.en;
    assign re = bus.rst & ~bus.en;

    sp_ram_mem u_mem (
        .clk   (bus.clk),
        .we    (we),
        .re    (re),
        .addr  (bus.addr),
        .wdata (bus.data_in),
        .rdata (rd_data)
    );

    // Qualifies the RAM output register: cleared at once by reset,
    // set by the first read edge afterwards.
    always_ff @(posedge bus.clk or negedge bus.rst) begin
        if (!bus.rst) begin
            rd_ok <= 1'b0;
        end else if (re) begin
            rd_ok <= 1'b1;
        end
    end

    assign bus.data_out = rd_ok ? rd_data : '0;

endmodule

// File: tb/tb_sp_ram_inf.sv
// Self-checking bench for sp_ram_inf: directed cases plus a
// randomized op stream against an array reference model.
module tb_sp_ram_inf;
    import sp_ram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;

    data_t ref_mem [DEPTH];
    bit    written [DEPTH];
    data_t exp_q;
    bit    exp_ok;

    sp_ram_if bus (.clk(clk), .rst(rst));

    sp_ram_inf dut (.bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input data_t got, input data_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // One operation: drive, pass the rising edge, update the model.
    task automatic step(input logic wr, input addr_t a, input data_t d);
        bus.en      = wr;
        bus.addr    = a;
        bus.data_in = d;
        @(posedge clk);
        #1;
        if (rst) begin
            if (wr) begin
                ref_mem[a] = d;
                written[a] = 1'b1;
            end else begin
                exp_q  = ref_mem[a];
                exp_ok = written[a];
            end
        end else begin
            exp_q  = '0;
            exp_ok = 1'b1;
        end
    endtask

    initial begin
        bus.en      = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;
        exp_q       = '0;
        exp_ok      = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset", bus.data_out, 8'h00);
        rst = 1'b1;

        step(1'b1, 8'hF2, 8'hA7);
        check("wr_no_thru", bus.data_out, 8'h00);
        step(1'b0, 8'hF2, 8'h00);
        check("rd_f2", bus.data_out, 8'hA7);

        #2 rst = 1'b0;
        #1 check("async_rst", bus.data_out, 8'h00);
        bus.en      = 1'b1;
        bus.addr    = 8'hF2;
        bus.data_in = 8'h55;
        @(posedge clk);
        #1 check("rst_hold1", bus.data_out, 8'h00);
        @(posedge clk);
        #1 check("rst_hold2", bus.data_out, 8'h00);
        rst = 1'b1;
        step(1'b0, 8'hF2, 8'h00);
        check("rst_no_wr", bus.data_out, 8'hA7);

        step(1'b1, 8'h00, 8'h11);
        step(1'b1, 8'hFF, 8'hEE);
        step(1'b0, 8'h00, 8'h00);
        check("rd_00", bus.data_out, 8'h11);
        step(1'b0, 8'hFF, 8'h00);
        check("rd_ff", bus.data_out, 8'hEE);

        step(1'b0, 8'hF2, 8'h00);
        check("rd_f2_again", bus.data_out, 8'hA7);
        step(1'b1, 8'hF2, 8'h3C);
        check("wr_hold", bus.data_out, 8'hA7);
        step(1'b0, 8'hF2, 8'h00);
        check("rd_f2_new", bus.data_out, 8'h3C);

        step(1'b1, 8'h10, 8'h5A);
        rst = 1'b0;
        #1 check("pulse_rst", bus.data_out, 8'h00);
        step(1'b1, 8'h10, 8'hFF);
        check("pulse_hold", bus.data_out, 8'h00);
        rst = 1'b1;
        step(1'b0, 8'h10, 8'h00);
        check("rd_10", bus.data_out, 8'h5A);

        for (int i = 0; i < 500; i++) begin
            logic  wr;
            addr_t a;
            data_t d;
            wr = 1'($urandom_range(0, 1));
            d  = data_t'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                a = addr_t'($urandom);
            end else begin
                a = addr_t'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b0;
                step(wr, a, d);
                rst = 1'b1;
            end else begin
                step(wr, a, d);
            end
            if (exp_ok) begin
                check("rand", bus.data_out, exp_q);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
